fb_frame_ctrl: RTL and testbench

FB_FRAME_CTRL -- requirements
Module: fb_frame_ctrl

---
 rtl/fb_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_fb_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_frame_ctrl.sv
// Double-buffered framebuffer write controller: clears the back buffer, accepts
// rasterizer pixels, then waits for a display vsync falling edge to swap buffers.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// CLEAR    | fill back buffer with the latched clear colour, one word/cycle
// DRAW     | accept rasterizer pixels until frame_done
// WAIT_VS  | frame finished, hold off pixels until vsync falls
// SWAP     | one-cycle swap pulse, toggle buf_sel, count the frame
module fb_frame_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int FB_WORDS   = 76800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  px_valid,
    input  logic [ADDR_WIDTH-1:0] px_addr,
    input  logic [7:0]            px_data,
    output logic                  px_ready,
    input  logic                  frame_done,
    input  logic                  clear_en,
    input  logic [7:0]            clear_color,
    output logic                  fb_wea,
    output logic [ADDR_WIDTH-1:0] fb_addra,
    output logic [7:0]            fb_dina,
    output logic                  swap,
    output logic                  buf_sel,
    output logic [15:0]           frame_cnt,
    output logic                  busy,
    output logic                  oob_err
);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_DRAW    = 2'd1,
        S_WAIT_VS = 2'd2,
        S_SWAP    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   FB_WORDS_W = FB_WORDS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FB_WORDS - 1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [7:0]            clr_color_q;
    logic                  sync1_q, sync2_q, prev_q;
    logic                  fb_wea_q;
    logic [ADDR_WIDTH-1:0] fb_addra_q;
    logic [7:0]            fb_dina_q;
    logic                  swap_q, buf_sel_q, oob_q;
    logic [15:0]           frame_cnt_q;

    logic [7:0] clr_color_d;
    logic       vs_fall;
    logic       px_in_range;

    // The clear colour is sampled on the first CLEAR cycle, so it is used directly there.
    assign clr_color_d = (clr_addr_q == '0) ? clear_color : clr_color_q;
    assign vs_fall     = prev_q & ~sync2_q;
    assign px_in_range = ({1'b0, px_addr} < FB_WORDS_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLEAR;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            fb_wea_q    <= 1'b0;
            fb_addra_q  <= '0;
            fb_dina_q   <= '0;
            swap_q      <= 1'b0;
            buf_sel_q   <= 1'b0;
            frame_cnt_q <= '0;
            oob_q       <= 1'b0;
        end else begin
            sync1_q  <= vsync;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            fb_wea_q <= 1'b0;
            swap_q   <= 1'b0;
            case (state_q)
                S_CLEAR: begin
                    fb_wea_q   <= 1'b1;
                    fb_addra_q <= clr_addr_q;
                    fb_dina_q  <= clr_color_d;
                    if (clr_addr_q == '0) clr_color_q <= clear_color;
                    if (clr_addr_q == LAST_ADDR) begin
                        clr_addr_q <= '0;
                        state_q    <= S_DRAW;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (px_valid) begin
                        if (px_in_range) begin
                            fb_wea_q   <= 1'b1;
                            fb_addra_q <= px_addr;
                            fb_dina_q  <= px_data;
                        end else begin
                            oob_q <= 1'b1;
                        end
                    end
                    if (frame_done) state_q <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (vs_fall) begin
                        state_q     <= S_SWAP;
                        swap_q      <= 1'b1;
                        buf_sel_q   <= ~buf_sel_q;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                S_SWAP: begin
                    state_q <= clear_en ? S_CLEAR : S_DRAW;
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign px_ready  = (state_q == S_DRAW);
    assign busy      = (state_q != S_DRAW);
    assign fb_wea    = fb_wea_q;
    assign fb_addra  = fb_addra_q;
    assign fb_dina   = fb_dina_q;
    assign swap      = swap_q;
    assign buf_sel   = buf_sel_q;
    assign frame_cnt = frame_cnt_q;
    assign oob_err   = oob_q;

endmodule

// File: tb/tb_fb_frame_ctrl.sv
// Bench for fb_frame_ctrl with a 16-word framebuffer: vector table for pixel
// handling, hand sequences for clear/swap/reset, randomized pixels vs a write-list model.
module tb_fb_frame_ctrl;

    localparam int AW = 5;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic          px_valid;
    logic [AW-1:0] px_addr;
    logic [7:0]    px_data;
    logic          px_ready;
    logic          frame_done;
    logic          clear_en;
    logic [7:0]    clear_color;
    logic          fb_wea;
    logic [AW-1:0] fb_addra;
    logic [7:0]    fb_dina;
    logic          swap;
    logic          buf_sel;
    logic [15:0]   frame_cnt;
    logic          busy;
    logic          oob_err;

    fb_frame_ctrl #(.ADDR_WIDTH(AW), .FB_WORDS(FW)) dut (
        .clk(clk), .rst_n(rst_n), .vsync(vsync),
        .px_valid(px_valid), .px_addr(px_addr), .px_data(px_data), .px_ready(px_ready),
        .frame_done(frame_done), .clear_en(clear_en), .clear_color(clear_color),
        .fb_wea(fb_wea), .fb_addra(fb_addra), .fb_dina(fb_dina),
        .swap(swap), .buf_sel(buf_sel), .frame_cnt(frame_cnt), .busy(busy), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    typedef struct {
        logic          v;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic          e_we;
        logic [AW-1:0] e_a;
        logic [7:0]    e_d;
        logic          e_oob;
    } vec_t;

    wr_t obs[$];
    wr_t exp_q[$];
    int  cyc = 0;
    int  swap_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_wea) obs.push_back('{cyc, fb_addra, fb_dina});
        if (swap) swap_cnt <= swap_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!px_ready && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(px_ready), 1);
    endtask

    task automatic wait_swap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!swap && n < 8);
        chk("swap_seen", 32'(swap), 1);
    endtask

    task automatic check_clear(input logic [7:0] color);
        chk("clr_count", obs.size(), FW);
        for (int i = 0; i < FW && i < obs.size(); i++) begin
            chk("clr_addr", 32'(obs[i].a), i);
            chk("clr_data", 32'(obs[i].d), 32'(color));
            chk("clr_consec", obs[i].cyc - obs[0].cyc, i);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        int   n;
        logic exp_oob;

        tbl[0] = '{1'b1, 5'd3,  8'h7F, 1'b1, 5'd3,  8'h7F, 1'b0};
        tbl[1] = '{1'b1, 5'd16, 8'hEE, 1'b0, 5'd0,  8'h00, 1'b1};
        tbl[2] = '{1'b0, 5'd7,  8'h11, 1'b0, 5'd0,  8'h00, 1'b1};
        tbl[3] = '{1'b1, 5'd15, 8'h3C, 1'b1, 5'd15, 8'h3C, 1'b1};
        tbl[4] = '{1'b1, 5'd0,  8'hC3, 1'b1, 5'd0,  8'hC3, 1'b1};
        tbl[5] = '{1'b1, 5'd31, 8'h01, 1'b0, 5'd0,  8'h00, 1'b1};

        rst_n = 1'b0; vsync = 1'b1; px_valid = 1'b0; px_addr = '0; px_data = '0;
        frame_done = 1'b0; clear_en = 1'b1; clear_color = 8'hA5;
        repeat (3) tick();
        chk("rst_wea", 32'(fb_wea), 0);
        chk("rst_swap", 32'(swap), 0);
        chk("rst_bufsel", 32'(buf_sel), 0);
        chk("rst_framecnt", 32'(frame_cnt), 0);
        chk("rst_oob", 32'(oob_err), 0);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_ready", 32'(px_ready), 0);

        // initial clear, with an out-of-range pixel held off the whole time
        px_valid = 1'b1; px_addr = 5'd31; px_data = 8'h99;
        obs.delete();
        rst_n = 1'b1;
        wait_ready();
        px_valid = 1'b0;
        check_clear(8'hA5);
        chk("clr_holdoff_oob", 32'(oob_err), 0);
        chk("draw_busy", 32'(busy), 0);
        obs.delete();

        for (int i = 0; i < 6; i++) begin
            px_valid = tbl[i].v; px_addr = tbl[i].a; px_data = tbl[i].d;
            tick();
            chk($sformatf("vec%0d_wea", i), 32'(fb_wea), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                chk($sformatf("vec%0d_addr", i), 32'(fb_addra), 32'(tbl[i].e_a));
                chk($sformatf("vec%0d_data", i), 32'(fb_dina), 32'(tbl[i].e_d));
            end
            chk($sformatf("vec%0d_oob", i), 32'(oob_err), 32'(tbl[i].e_oob));
        end
        px_valid = 1'b0;
        tick();

        // frame_done together with a pixel
        px_valid = 1'b1; px_addr = 5'd5; px_data = 8'h5A; frame_done = 1'b1;
        tick();
        px_valid = 1'b0; frame_done = 1'b0;
        chk("fd_wea", 32'(fb_wea), 1);
        chk("fd_addr", 32'(fb_addra), 5);
        chk("fd_data", 32'(fb_dina), 32'h5A);
        chk("fd_ready", 32'(px_ready), 0);
        chk("fd_busy", 32'(busy), 1);
        obs.delete();
        px_valid = 1'b1; px_addr = 5'd9; frame_done = 1'b1;
        repeat (6) tick();
        px_valid = 1'b0; frame_done = 1'b0;
        chk("wait_noswap", swap_cnt, 0);
        chk("wait_nowrite", obs.size(), 0);

        // vsync fall in WAIT_VS -> swap, then clear
        clear_color = 8'h3C;
        vsync = 1'b0;
        wait_swap(n);
        chk("swap_latency_le4", 32'(n <= 4), 1);
        chk("swap1_bufsel", 32'(buf_sel), 1);
        chk("swap1_framecnt", 32'(frame_cnt), 1);
        chk("swap1_ready", 32'(px_ready), 0);
        obs.delete();
        tick();
        tick();
        clear_color = 8'hFF;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        wait_ready();
        check_clear(8'h3C);
        chk("clr_vs_noswap", swap_cnt, 1);
        chk("clr_vs_bufsel", 32'(buf_sel), 1);

        // vsync fall during DRAW is ignored
        clear_en = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (6) tick();
        chk("draw_vs_noswap", swap_cnt, 1);
        chk("draw_vs_bufsel", 32'(buf_sel), 1);
        chk("draw_vs_ready", 32'(px_ready), 1);

        // second swap without clear
        vsync = 1'b1; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (4) tick();
        obs.delete();
        vsync = 1'b0;
        wait_swap(n);
        chk("swap2_bufsel", 32'(buf_sel), 0);
        chk("swap2_framecnt", 32'(frame_cnt), 2);
        tick();
        chk("noclr_ready", 32'(px_ready), 1);
        chk("noclr_nowrite", obs.size(), 0);

        // third swap with clear, reset at clear address 8
        clear_en = 1'b1; clear_color = 8'h77;
        vsync = 1'b1; frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (4) tick();
        vsync = 1'b0;
        wait_swap(n);
        chk("swap3_framecnt", 32'(frame_cnt), 3);
        n = 0;
        while (!(fb_wea && fb_addra == 5'd8) && n < 40) begin
            tick();
            n++;
        end
        chk("clr8_reached", 32'(fb_wea && fb_addra == 5'd8), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_wea", 32'(fb_wea), 0);
        chk("midrst_framecnt", 32'(frame_cnt), 0);
        chk("midrst_bufsel", 32'(buf_sel), 0);
        chk("midrst_busy", 32'(busy), 1);
        tick();
        clear_color = 8'h5A;
        obs.delete();
        rst_n = 1'b1;
        wait_ready();
        check_clear(8'h5A);
        chk("midrst_oob", 32'(oob_err), 0);
        obs.delete();

        // randomized pixels against a write-list model
        exp_q.delete();
        exp_oob = 1'b0;
        for (int i = 0; i < 200; i++) begin
            px_valid = 1'($urandom_range(0, 1));
            px_addr  = ($urandom_range(0, 9) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 15));
            px_data  = 8'($urandom_range(0, 255));
            if (px_valid) begin
                if (int'(px_addr) < FW) exp_q.push_back('{0, px_addr, px_data});
                else exp_oob = 1'b1;
            end
            tick();
        end
        px_valid = 1'b0;
        tick();
        tick();
        chk("rnd_count", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk("rnd_addr", 32'(obs[i].a), 32'(exp_q[i].a));
            chk("rnd_data", 32'(obs[i].d), 32'(exp_q[i].d));
        end
        chk("rnd_oob", 32'(oob_err), 32'(exp_oob));
        chk("rnd_noswap", 32'(frame_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
